// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the Funct3 op encodings, the FSM state type and the constant
// results used by the divide special cases.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/muldiv_if.sv
// Request/write-back bundle between the core and the mul/div unit.
//   start, funct3, src_a, src_b, rd_in : request from the core (RD1/RD2 side)
//   busy, done, we, rd_out, result     : status and register-file write port
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, src_a, src_b, rd_in,
                  input  busy, done, we, rd_out, result);
  modport slave  (input  start, funct3, src_a, src_b, rd_in,
                  output busy, done, we, rd_out, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : muldiv_if.slave (request in, write-back triple + busy out)
// Operands are reduced to magnitudes on Start; 32 shift-add or restoring
// divide steps follow, then one FIX cycle applies signs and selects the
// result. Divide-by-zero and signed overflow skip straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_t      state, state_nx;
  logic [4:0]  count;
  logic [2:0]  op;
  logic [31:0] mag;      // multiplicand (mul) or divisor (div)
  logic [63:0] acc;      // product, or {unused, dividend->quotient}
  logic [31:0] rem;
  logic        neg_q, neg_r;
  logic [31:0] result;
  logic [4:0]  rd;

  // Request decode (meaningful in IDLE only)
  logic        a_sgn, b_sgn, sa, sb, div_op, div0, ovf, special;
  logic [31:0] abs_a, abs_b, special_res;

  always_comb begin
    a_sgn  = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
             (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM);
    b_sgn  = (bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
             (bus.funct3 == F3_REM);
    sa     = a_sgn & bus.src_a[31];
    sb     = b_sgn & bus.src_b[31];
    abs_a  = sa ? -bus.src_a : bus.src_a;
    abs_b  = sb ? -bus.src_b : bus.src_b;
    div_op = bus.funct3[2];
    div0   = div_op && (bus.src_b == 32'd0);
    ovf    = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
             (bus.src_a == INT_MIN) && (bus.src_b == 32'hFFFF_FFFF);
    special = div0 || ovf;
    // funct3[1] distinguishes REM* from DIV* among divide ops
    if (div0) special_res = bus.funct3[1] ? bus.src_a : DIV0_Q;
    else      special_res = bus.funct3[1] ? 32'd0 : INT_MIN;
  end

  // One iteration of either datapath; op[2] picks which one is committed.
  logic [32:0] msum, trial, diff;
  logic        qbit;
  logic [63:0] prod;
  logic [31:0] quo, rmd, fix_res;

  always_comb begin
    msum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
    trial = {rem, acc[31]};
    diff  = trial - {1'b0, mag};
    qbit  = ~diff[32];  // no borrow: partial remainder >= divisor
    prod  = neg_q ? -acc : acc;
    quo   = neg_q ? -acc[31:0] : acc[31:0];
    rmd   = neg_r ? -rem : rem;
    case (op)
      F3_MUL:                       fix_res = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[63:32];
      F3_DIV, F3_DIVU:              fix_res = quo;
      default:                      fix_res = rmd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = special ? DONE : RUN;
      RUN:  if (count == 5'd0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      op     <= '0;
      mag    <= '0;
      acc    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      rd     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op    <= bus.funct3;
          rd    <= bus.rd_in;
          count <= 5'd31;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          mag   <= div_op ? abs_b : abs_a;
          acc   <= {32'd0, div_op ? abs_a : abs_b};
          rem   <= '0;
          if (special) result <= special_res;
        end
        RUN: begin
          if (count != 5'd0) count <= count - 5'd1;
          if (op[2]) begin
            acc <= {acc[63:32], acc[30:0], qbit};
            rem <= qbit ? diff[31:0] : trial[31:0];
          end else begin
            acc <= {msum, acc[31:1]};
          end
        end
        FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.we     = (state == DONE) && (rd != 5'd0);
  assign bus.rd_out = rd;
  assign bus.result = result;

endmodule
